// File: rtl/ucode_controller.sv
// ucode_controller: fetches 16-bit instructions over valid/ready, keeps the pc and
// sequences each one through FETCH/READ/WRITE/OUT/HALT micro-steps that drive the datapath.
// Ports: clk, rst (async, active-low); instr/instr_valid/instr_ready fetch handshake;
// pc next fetch address; z_flag/n_flag branch conditions (o_flag reserved);
// ie/write/reada/readb/en/oe/bypassa/bypassb/op/waddr/ra/rb/offset datapath controls;
// halted set once HALT executes.
module ucode_controller #(
    parameter int          M      = 3,
    parameter int          N      = 8,
    parameter logic [2:0]  OP_ADD = 3'b000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic [N-1:0] pc,
    input  logic         z_flag,
    input  logic         n_flag,
    input  logic         o_flag,
    output logic         ie,
    output logic         write,
    output logic         reada,
    output logic         readb,
    output logic         en,
    output logic         oe,
    output logic         bypassa,
    output logic         bypassb,
    output logic [2:0]   op,
    output logic [M-1:0] waddr,
    output logic [M-1:0] ra,
    output logic [M-1:0] rb,
    output logic [N-1:0] offset,
    output logic         halted
);
    typedef enum logic [2:0] {S_FETCH, S_READ, S_WRITE, S_OUT, S_HALT} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_ir;
    logic [N-1:0] r_pc;
    logic [3:0]  w_opc;
    logic [N-1:0] w_sext;
    logic        w_is_alu, w_is_addi, w_is_in, w_is_out, w_uses_a, w_taken, w_accept;
    logic        w_unused;
    assign w_unused  = o_flag;
    assign w_opc     = r_ir[15:12];
    assign w_sext    = {{(N-6){r_ir[5]}}, r_ir[5:0]};
    assign w_is_alu  = ~w_opc[3];
    assign w_is_addi = w_opc == 4'h8;
    assign w_is_in   = w_opc == 4'h9;
    assign w_is_out  = w_opc == 4'hA;
    assign w_uses_a  = w_is_alu | w_is_addi | w_is_out;
    assign w_taken   = (w_opc == 4'hB && z_flag) || (w_opc == 4'hC && n_flag) || w_opc == 4'hD;
    assign w_accept  = r_state == S_FETCH && instr_valid;
    assign pc          = r_pc;
    assign halted      = r_state == S_HALT;
    // rst is folded in so ready drops the moment reset asserts
    assign instr_ready = rst && r_state == S_FETCH;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ir <= instr;
                r_pc <= r_pc + N'(1);
            end else if (r_state == S_READ && w_taken) begin
                // pc already points past the branch, so the offset is relative to branch+1
                r_pc <= r_pc + w_sext;
            end
        end
    end
    always_comb begin
        w_next  = r_state;
        ie      = 1'b0;
        write   = 1'b0;
        reada   = 1'b0;
        readb   = 1'b0;
        en      = 1'b0;
        oe      = 1'b0;
        bypassa = 1'b0;
        bypassb = 1'b0;
        op      = '0;
        waddr   = '0;
        ra      = '0;
        rb      = '0;
        offset  = '0;
        case (r_state)
            S_FETCH: begin
                if (instr_valid)
                    w_next = instr[15:12] == 4'h9 ? S_WRITE :
                             instr[15:12] == 4'hE ? S_FETCH :
                             instr[15:12] == 4'hF ? S_HALT  : S_READ;
            end
            S_READ: begin
                reada   = w_uses_a;
                readb   = w_is_alu;
                en      = w_uses_a;
                ra      = w_uses_a ? r_ir[6 +: M] : '0;
                rb      = w_is_alu ? r_ir[3 +: M] : '0;
                op      = w_is_alu ? w_opc[2:0] : w_uses_a ? OP_ADD : 3'b000;
                bypassb = w_is_addi | w_is_out;
                offset  = w_is_addi ? w_sext : '0;
                w_next  = w_is_out ? S_OUT : (w_is_alu | w_is_addi) ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                // only ALU, ADDI and IN reach WRITE; the first two keep the READ operand setup
                write   = 1'b1;
                waddr   = r_ir[9 +: M];
                ie      = w_is_in;
                en      = ~w_is_in;
                ra      = w_is_in ? '0 : r_ir[6 +: M];
                rb      = w_is_alu ? r_ir[3 +: M] : '0;
                op      = w_is_alu ? w_opc[2:0] : w_is_addi ? OP_ADD : 3'b000;
                bypassb = w_is_addi;
                offset  = w_is_addi ? w_sext : '0;
                w_next  = S_FETCH;
            end
            S_OUT: begin
                oe     = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_ucode_controller.sv
// tb_ucode_controller: table vectors, directed corner sequences and random instructions
// checked against an instruction-level reference model.
module tb_ucode_controller;
    localparam int M = 3;
    localparam int N = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  instr;
    logic         instr_valid, instr_ready, z_flag, n_flag, o_flag;
    logic [N-1:0] pc, offset;
    logic         ie, write, reada, readb, en, oe, bypassa, bypassb, halted;
    logic [2:0]   op;
    logic [M-1:0] waddr, ra, rb;
    always #5 clk = ~clk;
    ucode_controller #(.M(M), .N(N), .OP_ADD(3'b000)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .z_flag(z_flag), .n_flag(n_flag),
        .o_flag(o_flag), .ie(ie), .write(write), .reada(reada), .readb(readb),
        .en(en), .oe(oe), .bypassa(bypassa), .bypassb(bypassb), .op(op),
        .waddr(waddr), .ra(ra), .rb(rb), .offset(offset), .halted(halted)
    );
    typedef struct packed {
        logic       ready, halted, ie, write, reada, readb, en, oe, bypassa, bypassb;
        logic [2:0] op, waddr, ra, rb;
        logic [7:0] offset, pc;
    } ctl_t;
    typedef struct {
        logic [15:0] ins;
        logic        z, n;
        int          cycles;
        logic [7:0]  delta;
    } vec_t;
    ctl_t       got;
    ctl_t       exp_q[$];
    logic [7:0] m_pc;
    int         passed = 0;
    int         total = 0;
    vec_t       vt[10];
    always_comb begin
        got = '0;
        got.ready = instr_ready; got.halted = halted; got.ie = ie; got.write = write;
        got.reada = reada; got.readb = readb; got.en = en; got.oe = oe;
        got.bypassa = bypassa; got.bypassb = bypassb; got.op = op; got.waddr = waddr;
        got.ra = ra; got.rb = rb; got.offset = offset; got.pc = pc;
    end
    task automatic chk(input string nm, input int g, input int e);
        total++;
        if (g == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, g, e);
    endtask
    task automatic chk_ctl(input string nm, input ctl_t e);
        total++;
        if (got === e) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, e);
    endtask
    // Expected per-cycle outputs of one accepted instruction, from the instruction-set rules.
    task automatic model(input logic [15:0] ins, input logic z, input logic n);
        ctl_t rd_s, wr_s;
        logic [3:0] opc;
        logic [7:0] sx;
        opc  = ins[15:12];
        sx   = {{2{ins[5]}}, ins[5:0]};
        m_pc = m_pc + 8'd1;
        rd_s = '0;
        rd_s.pc = m_pc;
        wr_s = rd_s;
        if (!opc[3] || opc == 4'h8 || opc == 4'hA) begin
            rd_s.reada = 1'b1; rd_s.en = 1'b1; rd_s.ra = ins[8:6];
        end
        if (!opc[3]) begin
            rd_s.readb = 1'b1; rd_s.rb = ins[5:3]; rd_s.op = opc[2:0];
        end else if (opc == 4'h8 || opc == 4'hA) begin
            rd_s.bypassb = 1'b1; rd_s.op = 3'b000; rd_s.offset = opc == 4'h8 ? sx : 8'h00;
        end
        if (!opc[3] || opc == 4'h8) begin
            wr_s = rd_s; wr_s.reada = 1'b0; wr_s.readb = 1'b0;
            wr_s.write = 1'b1; wr_s.waddr = ins[11:9];
            exp_q.push_back(rd_s); exp_q.push_back(wr_s);
        end else if (opc == 4'h9) begin
            wr_s.ie = 1'b1; wr_s.write = 1'b1; wr_s.waddr = ins[11:9];
            exp_q.push_back(wr_s);
        end else if (opc == 4'hA) begin
            wr_s.oe = 1'b1;
            exp_q.push_back(rd_s); exp_q.push_back(wr_s);
        end else if (opc != 4'hE) begin
            exp_q.push_back(rd_s);
            if (opc == 4'hD || (opc == 4'hB && z) || (opc == 4'hC && n)) m_pc = m_pc + sx;
        end
    endtask
    // Issues one instruction at a negedge in FETCH and checks every cycle until the next FETCH.
    task automatic run_model(input logic [15:0] ins, input logic z, input logic n);
        ctl_t e;
        @(negedge clk);
        e = '0; e.ready = 1'b1; e.pc = m_pc;
        chk_ctl("fetch", e);
        instr = ins; instr_valid = 1'b1; z_flag = z; n_flag = n;
        model(ins, z, n);
        @(negedge clk);
        instr = 16'($urandom);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_ctl("step", e);
            instr_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        instr_valid = 1'b0;
    endtask
    task automatic run_vec(input vec_t v);
        int cnt;
        @(negedge clk);
        instr = v.ins; instr_valid = 1'b1; z_flag = v.z; n_flag = v.n;
        @(negedge clk);
        instr_valid = 1'b0;
        cnt = 1;
        while (!instr_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("vec_cycles", cnt, v.cycles);
        m_pc = m_pc + v.delta;
        chk("vec_pc", int'(pc), int'(m_pc));
    endtask
    task automatic do_reset();
        rst = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_pc = 8'h00;
    endtask
    initial begin
        ctl_t e;
        logic [15:0] ri;
        vt[0] = '{16'h7608, 1'b0, 1'b0, 3, 8'h01};
        vt[1] = '{16'h843F, 1'b0, 1'b0, 3, 8'h01};
        vt[2] = '{16'hA080, 1'b0, 1'b0, 3, 8'h01};
        vt[3] = '{16'h9000, 1'b0, 1'b0, 2, 8'h01};
        vt[4] = '{16'hE000, 1'b0, 1'b0, 1, 8'h01};
        vt[5] = '{16'hB03D, 1'b1, 1'b0, 2, 8'hFE};
        vt[6] = '{16'hB03D, 1'b0, 1'b0, 2, 8'h01};
        vt[7] = '{16'hC004, 1'b0, 1'b1, 2, 8'h05};
        vt[8] = '{16'hC004, 1'b0, 1'b0, 2, 8'h01};
        vt[9] = '{16'hD001, 1'b0, 1'b0, 2, 8'h02};
        instr = '0; instr_valid = 1'b0; z_flag = 1'b0; n_flag = 1'b0; o_flag = 1'b0; m_pc = 8'h00;
        #1 rst = 1'b0;
        #3 e = '0;
        chk_ctl("reset_state", e);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("ready_after_reset", int'(instr_ready), 1);
        chk("halted_after_reset", int'(halted), 0);
        for (int i = 0; i < 10; i++) run_vec(vt[i]);
        do_reset();
        @(negedge clk);
        instr = 16'h7608; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("alu_read_readb", int'(readb), 1);
        @(negedge clk);
        chk("alu_write_pre", int'(write), 1);
        #2 rst = 1'b0;
        #1 chk("rst_write_async", int'(write), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_ready_low", int'(instr_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        m_pc = 8'h00;
        #1 chk("rel_ready", int'(instr_ready), 1);
        chk("rel_halted", int'(halted), 0);
        run_model(16'h9000, 1'b0, 1'b0);
        run_model(16'h9200, 1'b0, 1'b0);
        chk("in_in_pc", int'(pc), 2);
        run_model(16'h7608, 1'b0, 1'b0);
        run_model(16'h843F, 1'b0, 1'b0);
        run_model(16'hA080, 1'b0, 1'b0);
        chk("pc_before_bz", int'(pc), 5);
        run_model(16'hB03D, 1'b1, 1'b0);
        chk("bz_taken_pc", int'(pc), 3);
        do_reset();
        repeat (5) run_model(16'hE000, 1'b0, 1'b0);
        run_model(16'hB03D, 1'b0, 1'b0);
        chk("bz_not_taken_pc", int'(pc), 6);
        do_reset();
        repeat (255) run_model(16'hE000, 1'b0, 1'b0);
        chk("pc_ff", int'(pc), 255);
        run_model(16'hD001, 1'b0, 1'b0);
        chk("bra_wrap_pc", int'(pc), 1);
        for (int i = 0; i < 300; i++) begin
            ri = 16'($urandom);
            if (ri[15:12] == 4'hF) ri[15:12] = 4'hD;
            run_model(ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        instr = 16'hF000; instr_valid = 1'b1;
        m_pc = m_pc + 8'd1;
        repeat (20) begin
            @(negedge clk);
            e = '0; e.halted = 1'b1; e.pc = m_pc;
            chk_ctl("halt_hold", e);
        end
        do_reset();
        #1 chk("halt_exit_ready", int'(instr_ready), 1);
        chk("halt_exit_halted", int'(halted), 0);
        run_model(16'hE000, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
